// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_arb_pkg : shared types and port indices for the SDRAM arbiter (Rev 1.0)
// ----------------------------------------------------------------------------
package sdram_arb_pkg;

  localparam int NUM_PORTS     = 3;
  localparam int PORT_CHR      = 0;
  localparam int PORT_PRG      = 1;
  localparam int PORT_MCU      = 2;
  localparam int ARB_ADDR_BITS = 22;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                     we;
    logic [ARB_ADDR_BITS-1:0] addr;
    logic [15:0]              wdata;
    logic [1:0]               wm;
  } arb_cmd_t;

endpackage
`default_nettype wire

// File: rtl/sdram_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_arbiter_if : requester-side and controller-side bus of the arbiter (Rev 1.0)
// ----------------------------------------------------------------------------
interface sdram_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_BITS = 22
) ();

  logic [NUM_PORTS-1:0]                p_req;
  logic [NUM_PORTS-1:0]                p_we;
  logic [NUM_PORTS-1:0][ADDR_BITS-1:0] p_addr;
  logic [NUM_PORTS-1:0][15:0]          p_wdata;
  logic [NUM_PORTS-1:0][1:0]           p_wm;
  logic [NUM_PORTS-1:0]                p_ack;
  logic [NUM_PORTS-1:0][15:0]          p_rdata;

  logic                 ctrl_req;
  logic                 ctrl_we;
  logic [ADDR_BITS-1:0] ctrl_addr;
  logic [15:0]          ctrl_wdata;
  logic [1:0]           ctrl_wm;
  logic [15:0]          ctrl_rdata;
  logic                 ctrl_ack;
  logic                 timeout_err;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata, p_wm, ctrl_rdata, ctrl_ack,
    output p_ack, p_rdata, ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata, ctrl_wm, timeout_err
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata, p_wm, ctrl_rdata, ctrl_ack,
    input  p_ack, p_rdata, ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata, ctrl_wm, timeout_err
  );

endinterface
`default_nettype wire

// File: rtl/arb_req_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// arb_req_buf : one-deep pending request buffer, newest request wins (Rev 1.0)
// ----------------------------------------------------------------------------
module arb_req_buf
  import sdram_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_req,
  input  arb_cmd_t i_cmd,
  input  logic     i_grant,
  output logic     o_pending,
  output arb_cmd_t o_cmd
);

  logic     r_pending;
  arb_cmd_t r_cmd;

  // A request in the grant cycle refills the buffer behind the granted entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_cmd     <= '0;
    end else if (i_req) begin
      r_pending <= 1'b1;
      r_cmd     <= i_cmd;
    end else if (i_grant) begin
      r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;
  assign o_cmd     = r_cmd;

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_arbiter : 3-port priority arbiter with MCU starvation guard in front of
//                 a single SDRAM controller port (Rev 1.0)
// ----------------------------------------------------------------------------
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_BITS    = 22,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 63
) (
  input  logic           clk,
  input  logic           rst,
  sdram_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t                     r_state;
  arb_state_t                     w_state_nxt;
  logic [NUM_PORTS-1:0]           w_pending;
  logic [NUM_PORTS-1:0]           w_grant;
  arb_cmd_t [NUM_PORTS-1:0]       w_buf_cmd;
  logic [1:0]                     w_winner;
  logic                           w_issue;
  logic                           w_done;
  logic                           w_abort;
  logic                           w_force_mcu;

  logic [1:0]                     r_owner;
  logic [SW-1:0]                  r_starve;
  logic [TW-1:0]                  r_timer;
  logic                           r_ctrl_req;
  arb_cmd_t                       r_ctrl_cmd;
  logic [NUM_PORTS-1:0]           r_p_ack;
  logic [NUM_PORTS-1:0][15:0]     r_p_rdata;
  logic                           r_timeout_err;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_buf
    arb_cmd_t w_in;
    assign w_in.we    = bus.p_we[gi];
    assign w_in.addr  = ARB_ADDR_BITS'(bus.p_addr[gi]);
    assign w_in.wdata = bus.p_wdata[gi];
    assign w_in.wm    = bus.p_wm[gi];

    arb_req_buf u_buf (
      .clk       (clk),
      .rst       (rst),
      .i_req     (bus.p_req[gi]),
      .i_cmd     (w_in),
      .i_grant   (w_grant[gi]),
      .o_pending (w_pending[gi]),
      .o_cmd     (w_buf_cmd[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_winner    = 2'(PORT_CHR);
    w_grant     = '0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_force_mcu = w_pending[PORT_MCU] && (r_starve == SW'(STARVE_LIMIT));
    case (r_state)
      IDLE: begin
        if (|w_pending) begin
          w_issue     = 1'b1;
          w_state_nxt = WAIT;
          if (w_force_mcu) begin
            w_winner = 2'(PORT_MCU);
          end else if (w_pending[PORT_CHR]) begin
            w_winner = 2'(PORT_CHR);
          end else if (w_pending[PORT_PRG]) begin
            w_winner = 2'(PORT_PRG);
          end else begin
            w_winner = 2'(PORT_MCU);
          end
          w_grant[w_winner] = 1'b1;
        end
      end
      WAIT: begin
        // An ack landing on the last permitted cycle still completes normally.
        if (bus.ctrl_ack) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner       <= '0;
      r_starve      <= '0;
      r_timer       <= '0;
      r_ctrl_req    <= 1'b0;
      r_ctrl_cmd    <= '0;
      r_p_ack       <= '0;
      r_p_rdata     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ctrl_req <= w_issue;
      r_p_ack    <= '0;

      if (w_issue) begin
        r_owner    <= w_winner;
        r_ctrl_cmd <= w_buf_cmd[w_winner];
        r_timer    <= '0;
      end else if (r_state == WAIT) begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_done) begin
        r_p_ack[r_owner] <= 1'b1;
        if (!r_ctrl_cmd.we) begin
          r_p_rdata[r_owner] <= bus.ctrl_rdata;
        end
      end

      if (w_abort) begin
        r_timeout_err <= 1'b1;
      end

      // Only grants lost while MCU is actually waiting count toward the guard.
      if (!w_pending[PORT_MCU]) begin
        r_starve <= '0;
      end else if (w_issue) begin
        if (w_winner == 2'(PORT_MCU)) begin
          r_starve <= '0;
        end else if (r_starve != SW'(STARVE_LIMIT)) begin
          r_starve <= r_starve + 1'b1;
        end
      end
    end
  end

  assign bus.ctrl_req    = r_ctrl_req;
  assign bus.ctrl_we     = r_ctrl_cmd.we;
  assign bus.ctrl_addr   = ADDR_BITS'(r_ctrl_cmd.addr);
  assign bus.ctrl_wdata  = r_ctrl_cmd.wdata;
  assign bus.ctrl_wm     = r_ctrl_cmd.wm;
  assign bus.p_ack       = r_p_ack;
  assign bus.p_rdata     = r_p_rdata;
  assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sdram_arbiter : scoreboard bench with a transaction-level arbiter model (Rev 1.0)
// ----------------------------------------------------------------------------
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int AB    = 22;
  localparam int LIMIT = 4;
  localparam int TMO   = 63;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.ADDR_BITS(AB)) bus ();

  sdram_arbiter #(
    .ADDR_BITS    (AB),
    .STARVE_LIMIT (LIMIT),
    .TIMEOUT      (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        valid;
    logic        we;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wm;
  } mreq_t;

  typedef struct {
    int   port;
    logic we;
  } exp_t;

  mreq_t       pend [3];
  exp_t        exp_q[$];
  int          grant_log[$];
  logic [21:0] addr_log[$];
  logic [15:0] m_rdata [3];
  logic        m_err;
  logic        exp_req_next;
  int          lost;
  int          wait_cycles;

  int n_vec  = 0;
  int n_fail = 0;

  logic        noack      = 1'b0;
  logic        slow       = 1'b0;
  logic        fixed_en   = 1'b0;
  logic [15:0] fixed_data = 16'h0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic pend_any();
    return pend[0].valid | pend[1].valid | pend[2].valid;
  endfunction

  // Controller model: acks after a random delay, or never when asked to hang.
  initial begin : responder
    int cnt;
    cnt = -1;
    bus.ctrl_ack   = 1'b0;
    bus.ctrl_rdata = 16'h0000;
    forever begin
      @(posedge clk); #2;
      bus.ctrl_ack = 1'b0;
      if (rst) begin
        cnt = -1;
      end else begin
        if (bus.ctrl_req) cnt = noack ? -1 : (slow ? 20 : int'($urandom_range(0, 5)));
        if (cnt == 0) begin
          bus.ctrl_ack   = 1'b1;
          bus.ctrl_rdata = fixed_en ? fixed_data : 16'($urandom);
          cnt = -1;
        end else if (cnt > 0) begin
          cnt--;
        end
      end
    end
  end

  // Monitor and reference model, sampled 1 ns after each rising edge.
  initial begin : monitor
    logic [2:0] exp_ack;
    exp_t       e;
    int         win;
    for (int p = 0; p < 3; p++) begin
      pend[p]    = '{1'b0, 1'b0, 22'h0, 16'h0, 2'b0};
      m_rdata[p] = 16'h0;
    end
    m_err = 1'b0; lost = 0; wait_cycles = 0; exp_req_next = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        chk("rst_ctrl_req", 64'(bus.ctrl_req), 64'd0);
        chk("rst_p_ack", 64'(bus.p_ack), 64'd0);
        chk("rst_p_rdata", 64'({bus.p_rdata[2], bus.p_rdata[1], bus.p_rdata[0]}), 64'd0);
        chk("rst_ctrl_bus", 64'({bus.ctrl_we, bus.ctrl_addr, bus.ctrl_wdata, bus.ctrl_wm}), 64'd0);
        chk("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
        for (int p = 0; p < 3; p++) begin
          pend[p].valid = 1'b0;
          m_rdata[p]    = 16'h0;
        end
        exp_q.delete();
        m_err = 1'b0; lost = 0;
      end else begin
        exp_ack = 3'b000;
        if (exp_q.size() > 0) begin
          wait_cycles++;
          if (bus.ctrl_ack) begin
            e = exp_q.pop_front();
            exp_ack[e.port] = 1'b1;
            if (!e.we) m_rdata[e.port] = bus.ctrl_rdata;
          end else if (wait_cycles == TMO) begin
            void'(exp_q.pop_front());
            m_err = 1'b1;
          end
        end
        chk("p_ack", 64'(bus.p_ack), 64'(exp_ack));
        chk("p_rdata", 64'({bus.p_rdata[2], bus.p_rdata[1], bus.p_rdata[0]}),
            64'({m_rdata[2], m_rdata[1], m_rdata[0]}));
        chk("timeout_err", 64'(bus.timeout_err), 64'(m_err));
        chk("ctrl_req_timing", 64'(bus.ctrl_req), 64'(exp_req_next));

        if (!pend[2].valid) lost = 0;
        if (bus.ctrl_req) begin
          if (pend[2].valid && lost == LIMIT) win = 2;
          else if (pend[0].valid) win = 0;
          else if (pend[1].valid) win = 1;
          else if (pend[2].valid) win = 2;
          else win = -1;
          if (win < 0) begin
            n_vec++; n_fail++;
            $display("FAIL grant_source: got ctrl_req expected no grant (nothing pending) at %0t", $time);
          end else begin
            chk("ctrl_we", 64'(bus.ctrl_we), 64'(pend[win].we));
            chk("ctrl_addr", 64'(bus.ctrl_addr), 64'(pend[win].addr));
            chk("ctrl_wdata", 64'(bus.ctrl_wdata), 64'(pend[win].wdata));
            chk("ctrl_wm", 64'(bus.ctrl_wm), 64'(pend[win].wm));
            exp_q.push_back('{win, pend[win].we});
            wait_cycles = 0;
            pend[win].valid = 1'b0;
            grant_log.push_back(win);
            addr_log.push_back(bus.ctrl_addr);
            if (win == 2) lost = 0;
            else if (pend[2].valid && lost < LIMIT) lost++;
          end
        end
        for (int p = 0; p < 3; p++) begin
          if (bus.p_req[p]) pend[p] = '{1'b1, bus.p_we[p], bus.p_addr[p], bus.p_wdata[p], bus.p_wm[p]};
        end
      end
      exp_req_next = !rst && (exp_q.size() == 0) && pend_any();
    end
  end

  task automatic set_port(input int p, input logic we, input logic [21:0] a,
                          input logic [15:0] d, input logic [1:0] m);
    bus.p_req[p]   = 1'b1;
    bus.p_we[p]    = we;
    bus.p_addr[p]  = a;
    bus.p_wdata[p] = d;
    bus.p_wm[p]    = m;
  endtask

  task automatic tick();
    @(posedge clk); #2;
    bus.p_req = '0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || pend_any()) && k < 400) begin
      @(posedge clk); #2;
      k++;
    end
    if (k >= 400) begin
      n_vec++; n_fail++;
      $display("FAIL wait_idle: got still busy after %0d cycles expected drained", k);
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (!bus.ctrl_req && k < 20) begin
      @(posedge clk); #3;
      k++;
    end
    if (!bus.ctrl_req) begin
      n_vec++; n_fail++;
      $display("FAIL wait_req: got no ctrl_req expected one within 20 cycles");
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no finish expected end of test by %0t", $time);
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1);
  end

  initial begin : stimulus
    int          base;
    int          idx;
    int          k;
    logic [15:0] snap;
    bus.p_req = '0; bus.p_we = '0; bus.p_addr = '0; bus.p_wdata = '0; bus.p_wm = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // CHR read with a known returned word
    fixed_en = 1'b1; fixed_data = 16'hBEEF;
    base = grant_log.size();
    set_port(0, 1'b0, 22'h000123, 16'h0, 2'b00);
    tick();
    wait_idle();
    fixed_en = 1'b0;
    chk("chr_read_addr", 64'(addr_log[base]), 64'h123);
    chk("chr_read_rdata", 64'(bus.p_rdata[0]), 64'hBEEF);

    // all three ports in one cycle
    base = grant_log.size();
    set_port(0, 1'b0, 22'h1, 16'h0, 2'b00);
    set_port(1, 1'b0, 22'h2, 16'h0, 2'b00);
    set_port(2, 1'b0, 22'h3, 16'h0, 2'b00);
    tick();
    wait_idle();
    chk("order_count", 64'(grant_log.size() - base), 64'd3);
    for (int i = 0; i < 3; i++) chk("order_port", 64'(grant_log[base + i]), 64'(i));

    // MCU starvation guard under continuous CHR/PRG traffic
    base = grant_log.size();
    set_port(0, 1'b0, 22'h10, 16'h0, 2'b00);
    set_port(1, 1'b0, 22'h20, 16'h0, 2'b00);
    set_port(2, 1'b1, 22'h30, 16'h1234, 2'b01);
    tick();
    for (int i = 0; i < 40; i++) begin
      set_port(0, 1'b0, 22'(i), 16'h0, 2'b00);
      set_port(1, 1'b0, 22'(i + 100), 16'h0, 2'b00);
      tick();
    end
    wait_idle();
    idx = -1;
    for (int i = base; i < grant_log.size(); i++) begin
      if (idx < 0 && grant_log[i] == 2) idx = i;
    end
    chk("starve_lost_grants", 64'(idx - base), 64'd4);

    // PRG masked write to top of address space
    base = grant_log.size();
    snap = m_rdata[1];
    set_port(1, 1'b1, 22'h3FFFFF, 16'h5A5A, 2'b10);
    tick();
    wait_idle();
    chk("prg_wr_addr", 64'(addr_log[base]), 64'h3FFFFF);
    chk("prg_wr_bus", 64'({bus.ctrl_we, bus.ctrl_wdata, bus.ctrl_wm}), 64'({1'b1, 16'h5A5A, 2'b10}));
    chk("prg_wr_rdata_held", 64'(bus.p_rdata[1]), 64'(snap));

    // PRG overwritten twice while CHR occupies the controller
    slow = 1'b1;
    base = grant_log.size();
    set_port(0, 1'b0, 22'h55, 16'h0, 2'b00);
    tick();
    repeat (3) tick();
    set_port(1, 1'b0, 22'h10, 16'h0, 2'b00);
    tick();
    set_port(1, 1'b0, 22'h20, 16'h0, 2'b00);
    tick();
    slow = 1'b0;
    wait_idle();
    chk("overwrite_count", 64'(grant_log.size() - base), 64'd2);
    chk("overwrite_addr", 64'(addr_log[base + 1]), 64'h20);

    // timeout, then the queued PRG request proceeds
    noack = 1'b1;
    set_port(0, 1'b0, 22'h77, 16'h0, 2'b00);
    tick();
    wait_req();
    noack = 1'b0;
    base = grant_log.size();
    set_port(1, 1'b0, 22'h88, 16'h0, 2'b00);
    tick();
    k = 0;
    while (!bus.timeout_err && k < 150) begin
      tick();
      k++;
    end
    chk("timeout_err_set", 64'(bus.timeout_err), 64'd1);
    wait_idle();
    chk("after_timeout_addr", 64'(addr_log[base]), 64'h88);

    // reset in the middle of a hung transaction
    noack = 1'b1;
    set_port(2, 1'b0, 22'h99, 16'h0, 2'b00);
    tick();
    wait_req();
    noack = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (20) tick();
    chk("rst_mid_wait_err", 64'(bus.timeout_err), 64'd0);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 5) == 0)
          set_port(p, 1'($urandom_range(0, 1)), 22'($urandom), 16'($urandom), 2'($urandom));
      end
      tick();
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
